// File: rtl/action_select_pkg.sv
// Shared definitions for the Q-learning next-hop selector: FSM encoding,
// memory map constants and the LFSR step function.
package action_select_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_SCAN,
        ST_DECIDE,
        ST_RANDSEL,
        ST_DONE
    } state_t;

    localparam logic [15:0] NCOUNT_ADDR       = 16'h0040;
    localparam logic [15:0] Q_BASE            = 16'h01C8;
    localparam int          MAX_NBR           = 64;
    localparam logic [15:0] NO_ROUTE          = 16'hFFFF;
    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    function automatic logic [15:0] lfsr_step(input logic [15:0] q);
        return {q[14:0], ^(q & LFSR_TAPS)};
    endfunction

    function automatic logic [6:0] clamp_count(input logic [15:0] raw);
        return (raw > 16'(MAX_NBR)) ? 7'(MAX_NBR) : raw[6:0];
    endfunction

endpackage

// File: rtl/action_select_if.sv
// Memory/handshake bundle between the action selector and its neighbours.
interface action_select_if;
    logic        start;
    logic [15:0] address;
    logic [15:0] data_in;
    logic [15:0] action;
    logic [15:0] besthop;
    logic        explored;
    logic        no_route;
    logic        done;

    modport master (
        input  start, data_in,
        output address, action, besthop, explored, no_route, done
    );

    modport slave (
        output start, data_in,
        input  address, action, besthop, explored, no_route, done
    );
endinterface

// File: rtl/action_select_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; a zero seed falls back to the default.
module action_select_lfsr16
    import action_select_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] seed_eff;

    assign seed_eff = (seed == 16'h0000) ? LFSR_DEFAULT_SEED : seed;

    always_ff @(posedge clock) begin
        if (reset) q <= seed_eff;
        else       q <= lfsr_step(q);
    end

endmodule

// File: rtl/action_select.sv
// Q-learning next-hop selector: reads neighbour Q-values, finds the best hop
// and picks an action epsilon-greedily.
module action_select
    import action_select_pkg::*;
#(
    parameter logic [7:0]  EPSILON = 8'd26,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input logic              clock,
    input logic              reset,
    action_select_if.master  bus
);

    state_t      state, state_nx;
    logic        start_q;
    logic        trig;
    logic [15:0] lfsr;

    logic [15:0] address_q, address_nx;
    logic [15:0] action_q, action_nx;
    logic [15:0] besthop_q, besthop_nx;
    logic        explored_q, explored_nx;
    logic        no_route_q, no_route_nx;
    logic        done_q, done_nx;

    logic [6:0]  n_q, n_nx;
    logic [6:0]  idx_q, idx_nx;
    logic [15:0] best_q_q, best_q_nx;
    logic [5:0]  best_idx_q, best_idx_nx;
    logic [7:0]  r_q, r_nx;

    action_select_lfsr16 u_lfsr (
        .clock (clock),
        .reset (reset),
        .seed  (SEED),
        .q     (lfsr)
    );

    assign trig = bus.start & ~start_q;

    assign bus.address  = address_q;
    assign bus.action   = action_q;
    assign bus.besthop  = besthop_q;
    assign bus.explored = explored_q;
    assign bus.no_route = no_route_q;
    assign bus.done     = done_q;

    always_ff @(posedge clock) begin
        start_q <= bus.start;
    end

    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        address_nx  = address_q;
        action_nx   = action_q;
        besthop_nx  = besthop_q;
        explored_nx = explored_q;
        no_route_nx = no_route_q;
        done_nx     = done_q;
        n_nx        = n_q;
        idx_nx      = idx_q;
        best_q_nx   = best_q_q;
        best_idx_nx = best_idx_q;
        r_nx        = r_q;

        case (state)
            ST_IDLE, ST_DONE: begin
                if (trig) begin
                    state_nx    = ST_FETCH;
                    address_nx  = NCOUNT_ADDR;
                    done_nx     = 1'b0;
                    explored_nx = 1'b0;
                    no_route_nx = 1'b0;
                end
            end
            ST_FETCH: state_nx = ST_LOAD;
            ST_LOAD: begin
                n_nx = clamp_count(bus.data_in);
                if (n_nx == 7'd0) begin
                    action_nx   = NO_ROUTE;
                    besthop_nx  = NO_ROUTE;
                    no_route_nx = 1'b1;
                    done_nx     = 1'b1;
                    state_nx    = ST_DONE;
                end else begin
                    address_nx = Q_BASE;
                    idx_nx     = 7'd0;
                    state_nx   = ST_SCAN;
                end
            end
            ST_SCAN: begin
                // data_in holds the entry addressed one cycle earlier (idx_q - 1)
                if (idx_q != 7'd0) begin
                    if (idx_q == 7'd1 || bus.data_in > best_q_q) begin
                        best_q_nx   = bus.data_in;
                        best_idx_nx = 6'(idx_q - 7'd1);
                    end
                end
                if (idx_q == n_q) begin
                    state_nx = ST_DECIDE;
                end else begin
                    idx_nx = idx_q + 7'd1;
                    if (idx_q + 7'd1 < n_q) address_nx = address_q + 16'd2;
                end
            end
            ST_DECIDE: begin
                besthop_nx = {10'd0, best_idx_q};
                if (lfsr[15:8] >= EPSILON) begin
                    action_nx   = {10'd0, best_idx_q};
                    explored_nx = 1'b0;
                    done_nx     = 1'b1;
                    state_nx    = ST_DONE;
                end else begin
                    r_nx     = lfsr[7:0];
                    state_nx = ST_RANDSEL;
                end
            end
            ST_RANDSEL: begin
                // repeated subtraction gives r mod n without a divider
                if (r_q >= {1'b0, n_q}) begin
                    r_nx = r_q - {1'b0, n_q};
                end else begin
                    action_nx   = {8'd0, r_q};
                    explored_nx = 1'b1;
                    done_nx     = 1'b1;
                    state_nx    = ST_DONE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            address_q  <= 16'd0;
            action_q   <= 16'd0;
            besthop_q  <= 16'd0;
            explored_q <= 1'b0;
            no_route_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            address_q  <= address_nx;
            action_q   <= action_nx;
            besthop_q  <= besthop_nx;
            explored_q <= explored_nx;
            no_route_q <= no_route_nx;
            done_q     <= done_nx;
        end
    end

    // Scan datapath needs no reset: LOAD initialises it before use
    always_ff @(posedge clock) begin
        n_q        <= n_nx;
        idx_q      <= idx_nx;
        best_q_q   <= best_q_nx;
        best_idx_q <= best_idx_nx;
        r_q        <= r_nx;
    end

endmodule

// File: tb/tb_action_select.sv
// Self-checking bench for action_select with a behavioural memory and selection model.
module tb_action_select;

    localparam logic [15:0] T_NCOUNT = 16'h0040;
    localparam logic [15:0] T_QBASE  = 16'h01C8;
    localparam int          T_EPS    = 26;
    localparam logic [15:0] T_SEED   = 16'hACE1;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    action_select_if bus();

    action_select #(.EPSILON(8'd26), .SEED(16'hACE1)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] count_word = 16'd0;
    logic [15:0] qmem [0:127];

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        int off;
        if (a == T_NCOUNT) return count_word;
        off = int'(a) - int'(T_QBASE);
        if (off >= 0 && off < 256 && (off % 2) == 0) return qmem[off / 2];
        return 16'hDEAD;
    endfunction

    function automatic bit in_qwin(input logic [15:0] a);
        int off;
        off = int'(a) - int'(T_QBASE);
        return (off >= 0 && off < 256);
    endfunction

    always @(posedge clock) bus.data_in <= mem_rd(bus.address);

    // Count distinct Q-table addresses presented by the DUT
    int          q_total = 0;
    logic [15:0] last_q_addr = 16'd0;
    logic [15:0] prev_addr = 16'd0;
    always @(posedge clock) begin
        if (bus.address != prev_addr && in_qwin(bus.address)) begin
            q_total     <= q_total + 1;
            last_q_addr <= bus.address;
        end
        prev_addr <= bus.address;
    end

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        int x;
        int fb;
        x  = int'(v);
        fb = ((x >> 15) ^ (x >> 13) ^ (x >> 12) ^ (x >> 10)) & 1;
        return 16'(((x << 1) | fb) & 32'hFFFF);
    endfunction

    function automatic logic [15:0] lfsr_ahead(input logic [15:0] v, input int k);
        logic [15:0] t;
        t = v;
        for (int i = 0; i < k; i++) t = lfsr_next(t);
        return t;
    endfunction

    logic [15:0] m_lfsr = T_SEED;
    always @(posedge clock) m_lfsr <= reset ? T_SEED : lfsr_next(m_lfsr);

    // Highest Q wins; the first (lowest) index wins a tie
    function automatic int ref_best(input int n);
        int b;
        b = 0;
        for (int i = 1; i < n; i++) if (qmem[i] > qmem[b]) b = i;
        return b;
    endfunction

    // want: 0 any, 1 exploit, 2 explore. Waits until the model LFSR will give the wanted decision.
    task automatic select(input int n, input int want, input int pulse_at,
                          output int lat, output int reads, output logic [15:0] dec_l);
        int guard;
        int qb;
        logic [15:0] l;
        guard = 0;
        forever begin
            @(posedge clock); #1;
            l = lfsr_ahead(m_lfsr, 4 + n);
            if (want == 0) break;
            if (want == 1 && int'(l[15:8]) >= T_EPS) break;
            if (want == 2 && int'(l[15:8]) < T_EPS) break;
            guard++;
            if (guard > 4000) break;
        end
        dec_l = l;
        qb = q_total;
        bus.start = 1'b1;
        lat = 0;
        while (lat < 400) begin
            @(posedge clock);
            lat++;
            if (lat == pulse_at) begin #1; bus.start = 1'b0; end
            if (lat == pulse_at + 1) begin #1; bus.start = 1'b1; end
            @(negedge clock);
            if (bus.done) break;
        end
        reads = q_total - qb;
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++; if (bus.address !== 16'd0) begin errors++; $display("FAIL reset_address got %h want 0000", bus.address); end
        checks++; if (bus.action !== 16'd0) begin errors++; $display("FAIL reset_action got %h want 0000", bus.action); end
        checks++; if (bus.besthop !== 16'd0) begin errors++; $display("FAIL reset_besthop got %h want 0000", bus.besthop); end
        checks++; if ({bus.explored, bus.no_route, bus.done} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got %b want 000", {bus.explored, bus.no_route, bus.done});
        end
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    task automatic test_exploit();
        int lat, reads;
        logic [15:0] dl;
        count_word = 16'd4;
        qmem[0] = 16'd10; qmem[1] = 16'd50; qmem[2] = 16'd50; qmem[3] = 16'd7;
        bus.start = 1'b0;
        select(4, 1, -1, lat, reads, dl);
        checks++; if (bus.besthop !== 16'd1) begin errors++; $display("FAIL exploit_besthop got %0d want 1", bus.besthop); end
        checks++; if (bus.action !== 16'd1) begin errors++; $display("FAIL exploit_action got %0d want 1", bus.action); end
        checks++; if (bus.explored !== 1'b0) begin errors++; $display("FAIL exploit_explored got %b want 0", bus.explored); end
        checks++; if (lat != 9) begin errors++; $display("FAIL exploit_latency got %0d want 9", lat); end
        checks++; if (reads != 4) begin errors++; $display("FAIL exploit_reads got %0d want 4", reads); end
    endtask

    task automatic test_no_route();
        int lat, reads;
        logic [15:0] dl;
        count_word = 16'd0;
        bus.start = 1'b0;
        select(0, 0, -1, lat, reads, dl);
        checks++; if (bus.action !== 16'hFFFF) begin errors++; $display("FAIL noroute_action got %h want ffff", bus.action); end
        checks++; if (bus.besthop !== 16'hFFFF) begin errors++; $display("FAIL noroute_besthop got %h want ffff", bus.besthop); end
        checks++; if (bus.no_route !== 1'b1) begin errors++; $display("FAIL noroute_flag got %b want 1", bus.no_route); end
        checks++; if (lat != 3) begin errors++; $display("FAIL noroute_latency got %0d want 3", lat); end
        checks++; if (reads != 0) begin errors++; $display("FAIL noroute_qreads got %0d want 0", reads); end
    endtask

    task automatic test_explore();
        int lat, reads, r;
        logic [15:0] dl;
        count_word = 16'd5;
        for (int i = 0; i < 128; i++) qmem[i] = 16'd0;
        bus.start = 1'b0;
        select(5, 2, -1, lat, reads, dl);
        r = int'(dl[7:0]);
        checks++; if (int'(dl[15:8]) >= T_EPS) begin errors++; $display("FAIL explore_setup got lfsr %h want high byte below %0d", dl, T_EPS); end
        checks++; if (bus.besthop !== 16'd0) begin errors++; $display("FAIL explore_besthop got %0d want 0", bus.besthop); end
        checks++; if (bus.action !== 16'(r % 5)) begin errors++; $display("FAIL explore_action got %0d want %0d", bus.action, r % 5); end
        checks++; if (bus.explored !== 1'b1) begin errors++; $display("FAIL explore_flag got %b want 1", bus.explored); end
        checks++; if (lat != 5 + 6 + r / 5) begin errors++; $display("FAIL explore_latency got %0d want %0d", lat, 11 + r / 5); end
    endtask

    task automatic test_clamp();
        int lat, reads, ea, el;
        logic [15:0] dl;
        count_word = 16'd200;
        for (int i = 0; i < 128; i++) qmem[i] = (i < 64) ? 16'($urandom_range(0, 16'hEFFF)) : 16'hFFFF;
        qmem[63] = 16'hF000;
        bus.start = 1'b0;
        select(64, 0, -1, lat, reads, dl);
        ea = (int'(dl[15:8]) < T_EPS) ? int'(dl[7:0]) % 64 : 63;
        el = (int'(dl[15:8]) < T_EPS) ? 64 + 6 + int'(dl[7:0]) / 64 : 69;
        checks++; if (bus.besthop !== 16'd63) begin errors++; $display("FAIL clamp_besthop got %0d want 63", bus.besthop); end
        checks++; if (last_q_addr !== T_QBASE + 16'd126) begin errors++; $display("FAIL clamp_last_addr got %h want %h", last_q_addr, T_QBASE + 16'd126); end
        checks++; if (reads != 64) begin errors++; $display("FAIL clamp_reads got %0d want 64", reads); end
        checks++; if (bus.action !== 16'(ea)) begin errors++; $display("FAIL clamp_action got %0d want %0d", bus.action, ea); end
        checks++; if (lat != el) begin errors++; $display("FAIL clamp_latency got %0d want %0d", lat, el); end
    endtask

    task automatic test_random();
        int lat, reads, cw, n, eb, ea, el;
        bit ex;
        logic [15:0] dl;
        for (int it = 0; it < 16; it++) begin
            cw = $urandom_range(1, 90);
            n = (cw > 64) ? 64 : cw;
            count_word = 16'(cw);
            for (int i = 0; i < 128; i++) qmem[i] = (it % 2 == 1) ? 16'($urandom_range(0, 7)) : 16'($urandom);
            bus.start = 1'b0;
            select(n, 0, -1, lat, reads, dl);
            ex = int'(dl[15:8]) < T_EPS;
            eb = ref_best(n);
            ea = ex ? int'(dl[7:0]) % n : eb;
            el = ex ? n + 6 + int'(dl[7:0]) / n : n + 5;
            checks++; if (bus.besthop !== 16'(eb)) begin errors++; $display("FAIL rand%0d_besthop got %0d want %0d", it, bus.besthop, eb); end
            checks++; if (bus.action !== 16'(ea)) begin errors++; $display("FAIL rand%0d_action got %0d want %0d", it, bus.action, ea); end
            checks++; if (bus.explored !== ex) begin errors++; $display("FAIL rand%0d_explored got %b want %b", it, bus.explored, ex); end
            checks++; if (lat != el) begin errors++; $display("FAIL rand%0d_latency got %0d want %0d", it, lat, el); end
            checks++; if (reads != n || bus.no_route !== 1'b0) begin
                errors++; $display("FAIL rand%0d_reads got %0d/%b want %0d/0", it, reads, bus.no_route, n);
            end
        end
    endtask

    task automatic test_reset_mid();
        int lat, reads, seen_done;
        logic [15:0] dl;
        count_word = 16'd10;
        for (int i = 0; i < 128; i++) qmem[i] = 16'(i * 3);
        bus.start = 1'b0;
        @(posedge clock); #1;
        bus.start = 1'b1;
        repeat (6) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        bus.start = 1'b0;
        @(negedge clock);
        checks++; if ({bus.address, bus.action, bus.besthop} !== 48'd0) begin
            errors++; $display("FAIL midreset_outputs got %h %h %h want zeros", bus.address, bus.action, bus.besthop);
        end
        checks++; if ({bus.explored, bus.no_route, bus.done} !== 3'b000) begin
            errors++; $display("FAIL midreset_flags got %b want 000", {bus.explored, bus.no_route, bus.done});
        end
        seen_done = 0;
        repeat (30) begin
            @(negedge clock);
            if (bus.done) seen_done++;
        end
        checks++; if (seen_done != 0) begin errors++; $display("FAIL midreset_no_done got %0d want 0", seen_done); end
        select(10, 1, -1, lat, reads, dl);
        checks++; if (bus.besthop !== 16'd9 || bus.action !== 16'd9) begin
            errors++; $display("FAIL midreset_resume got %0d/%0d want 9/9", bus.besthop, bus.action);
        end
        checks++; if (lat != 15) begin errors++; $display("FAIL midreset_latency got %0d want 15", lat); end
    endtask

    task automatic test_start_held();
        int lat, reads, bad, q0;
        logic [15:0] dl;
        logic [15:0] act0, addr0;
        count_word = 16'd10;
        for (int i = 0; i < 128; i++) qmem[i] = 16'd100;
        qmem[6] = 16'd500;
        bus.start = 1'b0;
        select(10, 1, 4, lat, reads, dl);
        checks++; if (lat != 15) begin errors++; $display("FAIL scanpulse_latency got %0d want 15", lat); end
        checks++; if (reads != 10) begin errors++; $display("FAIL scanpulse_reads got %0d want 10", reads); end
        checks++; if (bus.action !== 16'd6) begin errors++; $display("FAIL scanpulse_action got %0d want 6", bus.action); end
        act0 = bus.action;
        addr0 = bus.address;
        q0 = q_total;
        bad = 0;
        repeat (40) begin
            @(negedge clock);
            if (bus.done !== 1'b1 || bus.action !== act0 || bus.address !== addr0) bad++;
        end
        checks++; if (bad != 0 || q_total != q0) begin
            errors++; $display("FAIL held_start_retrigger got %0d changes %0d reads want 0 0", bad, q_total - q0);
        end
        bus.start = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0;
        for (int i = 0; i < 128; i++) qmem[i] = 16'd0;
        test_reset();
        test_exploit();
        test_no_route();
        test_explore();
        test_clamp();
        test_random();
        test_reset_mid();
        test_start_held();
        repeat (2) @(posedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
